// File: rtl/inv_diffusion.sv
// AES InvShiftRows then InvMixColumns on one 128-bit state, one column per cycle; result 5 cycles after accept.
// Accepts only in IDLE; the result holds in DONE until out_ready, and no new state is taken until then.
module inv_diffusion (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, MIX = 2'd2, DONE = 2'd3} state_t;

   state_t        state_q, state_d;
   logic [127:0]  st, st_d;
   logic [1:0]    col, col_d;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
      logic [7:0] a [4];
      logic [7:0] x2 [4];
      logic [7:0] x4 [4];
      logic [7:0] x8 [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      for (int i = 0; i < 4; i++) begin
         a[i]  = c[31-8*i -: 8];
         x2[i] = xtime(a[i]);
         x4[i] = xtime(x2[i]);
         x8[i] = xtime(x4[i]);
         m9[i] = x8[i] ^ a[i];
         mb[i] = x8[i] ^ x2[i] ^ a[i];
         md[i] = x8[i] ^ x4[i] ^ a[i];
         me[i] = x8[i] ^ x4[i] ^ x2[i];
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

   // Row r rotates right by r: destination column c takes source column (c-r) mod 4.
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
         end
      end
      return o;
   endfunction

   always_comb begin
      state_d = state_q;
      st_d    = st;
      col_d   = col;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               st_d    = in_data;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            st_d    = inv_shift_rows(st);
            col_d   = 2'd0;
            state_d = MIX;
         end
         MIX: begin
            for (int c = 0; c < 4; c++) begin
               if (col == 2'(c)) begin
                  st_d[127-32*c -: 32] = inv_mix_col(st[127-32*c -: 32]);
               end
            end
            col_d = col + 2'd1;
            if (col == 2'd3) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         st      <= '0;
         col     <= 2'd0;
      end else begin
         state_q <= state_d;
         st      <= st_d;
         col     <= col_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = (state_q == DONE);
   assign out_data  = st;

endmodule
